fir_stream_feeder: RTL and testbench

FIR_STREAM_FEEDER -- requirements
Module: fir_stream_feeder

---
 rtl/fir_stream_feeder.sv | 122 ++++++++++++
 tb/tb_fir_stream_feeder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fir_stream_feeder.sv
// rtl/fir_stream_feeder.sv - streams stored taps then frame pixels to a convolution core
module fir_stream_feeder #(
    parameter int TAP_ROW    = 3,
    parameter int TAP_COL    = 3,
    parameter int TAP_WIDTH  = 8,
    parameter int DATA_ROW   = 16,
    parameter int DATA_COL   = 16,
    parameter int DATA_WIDTH = 16,
    parameter int TAP_GAP    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic                  wr_sel,
    input  logic [7:0]            wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  start_i,
    input  logic                  hold_i,
    output logic [TAP_WIDTH-1:0]  tap_o,
    output logic                  tap_vld_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  data_vld_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  wr_err_o
);
    localparam int TAP_N  = TAP_ROW * TAP_COL;
    localparam int DATA_N = DATA_ROW * DATA_COL;
    localparam int CW_D   = $clog2(DATA_N + 1);
    localparam int CW_T   = $clog2(TAP_N + 1);
    localparam int CW     = (CW_D > CW_T) ? CW_D : CW_T;
    localparam int TAW    = (TAP_N > 1) ? $clog2(TAP_N) : 1;
    localparam int DAW    = (DATA_N > 1) ? $clog2(DATA_N) : 1;
    localparam int GW     = (TAP_GAP > 1) ? $clog2(TAP_GAP) : 1;

    typedef enum logic [2:0] {S_IDLE, S_TAP, S_GAP, S_DATA, S_DONE} state_t;

    logic [TAP_WIDTH-1:0]  tap_mem [TAP_N];
    logic [DATA_WIDTH-1:0] pix_mem [DATA_N];
    state_t                state;
    logic [CW-1:0]         cnt;
    logic [GW-1:0]         gap_cnt;
    logic                  tap_hit;
    logic                  pix_hit;

    assign tap_hit = wr_en && !wr_sel && ({24'd0, wr_addr} < 32'(TAP_N));
    assign pix_hit = wr_en &&  wr_sel && ({24'd0, wr_addr} < 32'(DATA_N));

    // Memories are deliberately outside the reset domain so contents survive an abort.
    always_ff @(posedge clk) begin
        if (!busy_o && tap_hit)
            tap_mem[TAW'(wr_addr)] <= wr_data[TAP_WIDTH-1:0];
        if (!busy_o && pix_hit)
            pix_mem[DAW'(wr_addr)] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            gap_cnt    <= '0;
            tap_o      <= '0;
            tap_vld_o  <= 1'b0;
            data_o     <= '0;
            data_vld_o <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            wr_err_o   <= 1'b0;
        end else begin
            tap_o      <= '0;
            tap_vld_o  <= 1'b0;
            data_o     <= '0;
            data_vld_o <= 1'b0;
            done_o     <= 1'b0;
            wr_err_o   <= wr_en && (busy_o || !(tap_hit || pix_hit));
            case (state)
                S_IDLE: begin
                    // busy_o is left high from DONE for the done_o cycle, then drops here
                    busy_o <= start_i;
                    if (start_i) begin
                        state <= S_TAP;
                        cnt   <= '0;
                    end
                end
                S_TAP: begin
                    tap_vld_o <= 1'b1;
                    tap_o     <= tap_mem[cnt[TAW-1:0]];
                    if (cnt == CW'(TAP_N - 1)) begin
                        cnt     <= '0;
                        gap_cnt <= '0;
                        state   <= (TAP_GAP == 0) ? S_DATA : S_GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GW'(TAP_GAP - 1)) begin
                        state <= S_DATA;
                        cnt   <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (!hold_i) begin
                        data_vld_o <= 1'b1;
                        data_o     <= pix_mem[cnt[DAW-1:0]];
                        if (cnt == CW'(DATA_N - 1))
                            state <= S_DONE;
                        else
                            cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    done_o <= 1'b1;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_stream_feeder.sv
// tb/tb_fir_stream_feeder.sv - randomized self-checking bench against a timeline model
module tb_fir_stream_feeder;
    localparam int TN   = 9;
    localparam int DN   = 256;
    localparam int GAP  = 4;
    localparam int MAXC = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic        wr_sel = 1'b0;
    logic [7:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        start_i = 1'b0;
    logic        hold_i = 1'b0;
    logic [7:0]  tap_o;
    logic        tap_vld_o;
    logic [15:0] data_o;
    logic        data_vld_o;
    logic        busy_o;
    logic        done_o;
    logic        wr_err_o;

    int vectors = 0;
    int errors  = 0;

    logic [7:0]  tap_m [TN];
    logic [15:0] pix_m [DN];

    fir_stream_feeder #(
        .TAP_ROW(3), .TAP_COL(3), .TAP_WIDTH(8),
        .DATA_ROW(16), .DATA_COL(16), .DATA_WIDTH(16), .TAP_GAP(GAP)
    ) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_addr(wr_addr), .wr_data(wr_data), .start_i(start_i), .hold_i(hold_i),
        .tap_o(tap_o), .tap_vld_o(tap_vld_o), .data_o(data_o), .data_vld_o(data_vld_o),
        .busy_o(busy_o), .done_o(done_o), .wr_err_o(wr_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic wr(input logic sel, input logic [7:0] addr, input logic [15:0] d);
        bit ok;
        @(posedge clk); #1;
        wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
        @(negedge clk);
        ok = sel ? (int'(addr) < DN) : (int'(addr) < TN);
        chk("wr_err", wr_err_o, !ok);
        if (ok) begin
            if (sel) pix_m[addr] = d;
            else     tap_m[addr] = d[7:0];
        end
    endtask

    // Builds the expected per-cycle timeline from the memory model, then drives and compares.
    task automatic xfer(input int hmode, input int restart_cyc, input int abort_word,
                        input int wr_cyc, input logic wsel, input logic [7:0] waddr,
                        input logic [15:0] wdata);
        bit          hold [MAXC];
        bit          tv [MAXC], dv [MAXC], bz [MAXC], dn [MAXC], er [MAXC];
        logic [7:0]  td [MAXC];
        logic [15:0] dd [MAXC];
        int          wcyc [DN];
        int          d0, c, n, last, done_c, ac, end_c;
        d0 = TN + 1 + GAP;
        for (int k = 0; k < MAXC; k++) begin
            tv[k] = 0; dv[k] = 0; bz[k] = 0; dn[k] = 0; er[k] = 0; td[k] = '0; dd[k] = '0;
            case (hmode)
                1:       hold[k] = (k >= d0 + 11) && (k <= d0 + 13);
                2:       hold[k] = ($urandom_range(0, 3) == 0);
                default: hold[k] = 0;
            endcase
        end
        if (wr_cyc == 0) begin
            if (wsel) pix_m[waddr] = wdata;
            else      tap_m[waddr] = wdata[7:0];
        end else if (wr_cyc > 0) begin
            er[wr_cyc + 1] = 1;
        end
        for (int i = 0; i < TN; i++) begin
            tv[i + 2] = 1;
            td[i + 2] = tap_m[i];
        end
        c = d0; n = 0; last = 0;
        while (n < DN && c < MAXC - 8) begin
            if (!hold[c]) begin
                dv[c + 1] = 1;
                dd[c + 1] = pix_m[n];
                wcyc[n]   = c + 1;
                last      = c + 1;
                n++;
            end
            c++;
        end
        done_c = last + 1;
        dn[done_c] = 1;
        for (int k = 1; k <= done_c; k++) bz[k] = 1;
        ac = -1;
        end_c = done_c + 3;
        if (abort_word >= 0) begin
            ac = wcyc[abort_word];
            end_c = ac + 6;
            for (int k = ac + 1; k < MAXC; k++) begin
                tv[k] = 0; dv[k] = 0; bz[k] = 0; dn[k] = 0; er[k] = 0; td[k] = '0; dd[k] = '0;
            end
        end

        @(posedge clk); #1;
        for (int k = 0; k <= end_c; k++) begin
            start_i = (k == 0) || (k == restart_cyc);
            hold_i  = hold[k];
            reset   = (k == ac);
            wr_en   = (k == wr_cyc);
            wr_sel  = wsel; wr_addr = waddr; wr_data = wdata;
            @(negedge clk);
            chk("tap_vld", tap_vld_o, tv[k]);
            chk("tap", tap_o, td[k]);
            chk("data_vld", data_vld_o, dv[k]);
            chk("data", data_o, dd[k]);
            chk("busy", busy_o, bz[k]);
            chk("done", done_o, dn[k]);
            chk("wr_err", wr_err_o, er[k]);
            @(posedge clk); #1;
        end
        start_i = 0; hold_i = 0; reset = 0; wr_en = 0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_tap", tap_o, 0);
        chk("rst_tap_vld", tap_vld_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_data_vld", data_vld_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_wr_err", wr_err_o, 0);
        reset = 1'b0;

        for (int i = 0; i < TN; i++) wr(1'b0, 8'(i), 16'(i + 1));
        for (int i = 0; i < DN; i++) wr(1'b1, 8'(i), 16'(i));

        xfer(0, -1, -1, -1, 1'b0, 8'd0, 16'd0);
        xfer(1, -1, -1, -1, 1'b0, 8'd0, 16'd0);

        wr(1'b0, 8'd9, 16'h00aa);
        wr(1'b0, 8'd200, 16'h0055);
        xfer(0, -1, -1, 50, 1'b1, 8'd5, 16'hbeef);
        xfer(0, -1, -1, 5, 1'b0, 8'd2, 16'h0077);
        xfer(0, -1, -1, -1, 1'b0, 8'd0, 16'd0);

        xfer(0, 100, -1, -1, 1'b0, 8'd0, 16'd0);
        xfer(0, -1, 100, -1, 1'b0, 8'd0, 16'd0);
        xfer(0, -1, -1, -1, 1'b0, 8'd0, 16'd0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1)
                wr(1'b1, 8'($urandom_range(0, 255)), 16'($urandom));
            else
                wr(1'b0, 8'($urandom_range(0, 15)), 16'($urandom));
        end
        xfer(2, -1, -1, 0, 1'b0, 8'($urandom_range(0, TN - 1)), 16'($urandom));
        xfer(2, 200, -1, 0, 1'b1, 8'($urandom_range(0, 255)), 16'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
